mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported instruction/data memory between the CPU fetch port
//  (PC-driven) and the load/store data port. One transaction at a time.
//  Data port has priority; fetch is protected from starvation by a wait counter.
//  Sits between cpu_top request ports and the memory, replacing the direct IMEM hookup.
// PARAMETERS
//  ADDR_W    32  address width, both ports and memory
//  DATA_W    32  data width
//  MAX_WAIT  4   data grants allowed while fetch waits before fetch must win (>=1)
// PORTS
//  clk        in   1       single clock, all logic on rising edge
//  reset      in   1       synchronous, active-high
//  if_req     in   1       fetch request (level)
//  if_addr    in   ADDR_W  fetch address, stable while if_req=1
//  if_gnt     out  1       1-cycle pulse: fetch accepted
//  if_valid   out  1       1-cycle pulse: if_rdata valid
//  if_rdata   out  DATA_W  fetched instruction
//  d_req      in   1       data request (level)
//  d_we       in   1       1=store, 0=load
//  d_addr     in   ADDR_W  data address, stable while d_req=1
//  d_wdata    in   DATA_W  store data, stable while d_req=1
//  d_gnt      out  1       1-cycle pulse: data accepted
//  d_valid    out  1       1-cycle pulse: load data valid / store complete
//  d_rdata    out  DATA_W  load data (meaningful only when d_we was 0)
//  mem_req    out  1       memory request, held until mem_ready
//  mem_we     out  1       memory write enable (always 0 for fetch)
//  mem_addr   out  ADDR_W  latched address
//  mem_wdata  out  DATA_W  latched store data
//  mem_ready  in   1       memory completes transfer in any cycle mem_req=1
//  mem_rdata  in   DATA_W  read data, valid when mem_ready=1
//  busy       out  1       1 when state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, wait_cnt=0; all outputs 0 (incl. addr/data/rdata regs).
//  - FSM states IDLE, BUSY_IF, BUSY_D. All outputs registered.
//  - IDLE, sampled at edge: none -> IDLE; only if_req -> BUSY_IF; only d_req -> BUSY_D;
//    both -> BUSY_IF if wait_cnt==MAX_WAIT else BUSY_D.
//  - On entry to BUSY_x: x_gnt=1 for that cycle only; mem_addr/mem_wdata/mem_we latched
//    from port x at the granting edge; mem_req=1 from first BUSY cycle.
//  - BUSY_x with mem_ready=1 -> IDLE; next cycle x_valid=1 and x_rdata=mem_rdata
//    captured at that edge. mem_ready=0 -> stay, mem_req/addr/wdata/we held unchanged.
//  - Min latency: req sampled edge N -> gnt cycle N+1 -> valid cycle N+2 (mem_ready
//    in N+1). Back-to-back: next grant earliest cycle N+3 (IDLE in N+2).
//  - Requester drops req the cycle after it sees gnt; req still high in IDLE = new txn.
//  - Requests arriving during BUSY are not sampled; they wait for IDLE.
//  - wait_cnt ($clog2(MAX_WAIT+1) bits): +1 on each data grant with if_req=1,
//    saturates at MAX_WAIT; cleared on any fetch grant; unchanged otherwise.
//  - x_rdata holds last captured value between valid pulses; d_rdata also updates on
//    store completion (value don't-care).
//  - Reset mid-transaction: abort, mem_req drops next cycle, no valid/gnt issued.
//  - busy = (state != IDLE), registered with state.
// TESTING
//  1. Only if_req, if_addr=0x10, mem_ready=1 always, mem_rdata=0x00500093 -> if_gnt
//     cycle 1, mem_addr=0x10 mem_we=0, if_valid cycle 2 with if_rdata=0x00500093.
//  2. if_req and d_req (load, 0x40) together at wait_cnt=0 -> d_gnt first, mem_addr=0x40;
//     fetch granted in next IDLE; wait_cnt 1 -> 0.
//  3. MAX_WAIT=4, d_req held high with if_req held high -> exactly 4 data grants, then
//     fetch grant, then data again; pattern D,D,D,D,IF repeats.
//  4. Store d_we=1 d_addr=0x80 d_wdata=0xDEADBEEF, mem_ready low 3 cycles -> mem_req,
//     mem_we=1, addr/wdata stable 4 cycles; d_valid one cycle after mem_ready.
//  5. Reset asserted during BUSY_D with mem_ready=0 -> next cycle IDLE, mem_req=0,
//     busy=0, no d_valid; all outputs 0.
//  6. Change if_addr during BUSY_IF -> mem_addr unchanged; no response to new address.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
//   Bundles the fetch port, the load/store data port, the shared memory port
//   and the busy status of mem_port_arbiter into one interface.
//
//   Fetch port : if_req, if_addr            -> arbiter
//                if_gnt, if_valid, if_rdata <- arbiter
//   Data port  : d_req, d_we, d_addr, d_wdata -> arbiter
//                d_gnt, d_valid, d_rdata      <- arbiter
//   Memory     : mem_req, mem_we, mem_addr, mem_wdata <- arbiter
//                mem_ready, mem_rdata                 -> arbiter
//   Status     : busy <- arbiter
//
//   modport slave  : the arbiter's view
//   modport master : the environment's view (CPU ports plus memory model)
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_valid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_valid, if_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_valid, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata,
    output busy
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_valid, if_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_valid, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata,
    input  busy
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-ported instruction/data memory between the CPU fetch
//   port and the load/store data port, one transaction at a time. The data
//   port normally wins; a wait counter guarantees that fetch is granted after
//   MAX_WAIT data grants taken while fetch was waiting.
//
//   Ports:
//     clk    : single clock, everything on the rising edge
//     reset  : synchronous, active-high; aborts any transaction in flight
//     bus    : mem_port_arbiter_if.slave (fetch port, data port, memory, busy)
//
//   Parameters:
//     ADDR_W   : address width of both ports and the memory
//     DATA_W   : data width
//     MAX_WAIT : data grants allowed while fetch waits (>= 1)
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  mem_port_arbiter_if.slave      bus
);

  localparam int WC_W = $clog2(MAX_WAIT + 1);
  localparam logic [WC_W-1:0] MAX_CNT = WC_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } state_t;

  state_t          state;
  logic [WC_W-1:0] wait_cnt;

  // Fetch wins only when it is the sole requester, or when it has already
  // watched MAX_WAIT data grants go by.
  logic grant_if;
  logic grant_d;

  always_comb begin
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (bus.if_req && (!bus.d_req || (wait_cnt == MAX_CNT))) begin
      grant_if = 1'b1;
    end else if (bus.d_req) begin
      grant_d = 1'b1;
    end
  end

  // Single registered FSM. Grant and valid strobes default low every cycle so
  // they come out as one-cycle pulses. The memory request fields are latched
  // at the granting edge and simply left alone while waiting on mem_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      bus.if_gnt    <= 1'b0;
      bus.if_valid  <= 1'b0;
      bus.if_rdata  <= '0;
      bus.d_gnt     <= 1'b0;
      bus.d_valid   <= 1'b0;
      bus.d_rdata   <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.busy      <= 1'b0;
    end else begin
      bus.if_gnt   <= 1'b0;
      bus.d_gnt    <= 1'b0;
      bus.if_valid <= 1'b0;
      bus.d_valid  <= 1'b0;

      case (state)
        IDLE: begin
          if (grant_if) begin
            state         <= BUSY_IF;
            bus.if_gnt    <= 1'b1;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= bus.if_addr;
            bus.mem_wdata <= '0;
            bus.busy      <= 1'b1;
            wait_cnt      <= '0;
          end else if (grant_d) begin
            state         <= BUSY_D;
            bus.d_gnt     <= 1'b1;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= bus.d_we;
            bus.mem_addr  <= bus.d_addr;
            bus.mem_wdata <= bus.d_wdata;
            bus.busy      <= 1'b1;
            // Only a data grant that overtakes a waiting fetch counts.
            if (bus.if_req && (wait_cnt != MAX_CNT)) begin
              wait_cnt <= wait_cnt + WC_W'(1);
            end
          end
        end

        BUSY_IF: begin
          if (bus.mem_ready) begin
            state        <= IDLE;
            bus.mem_req  <= 1'b0;
            bus.busy     <= 1'b0;
            bus.if_valid <= 1'b1;
            bus.if_rdata <= bus.mem_rdata;
          end
        end

        BUSY_D: begin
          if (bus.mem_ready) begin
            state       <= IDLE;
            bus.mem_req <= 1'b0;
            bus.busy    <= 1'b0;
            bus.d_valid <= 1'b1;
            bus.d_rdata <= bus.mem_rdata;
          end
        end

        default: begin
          state       <= IDLE;
          bus.mem_req <= 1'b0;
          bus.busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
